// File: rtl/bram_mport_pkg.sv
// Shared types and sizing helpers for the multi-port BRAM front end.
package bram_mport_pkg;

    // Controller states: grant, drive the access, wait out read latency,
    // optional write read-back, and capture of the response data.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_RWAIT  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Width of the read-latency counter; it only has to count RD_LAT-1
    // wait cycles, but never collapses below one bit.
    function automatic int lat_cnt_w(input int rd_lat);
        if (rd_lat > 2) begin
            return $clog2(rd_lat);
        end else begin
            return 1;
        end
    endfunction

    // Width of a channel index for n requesters (at least one bit).
    function automatic int idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/bram_mport_if_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last-granted
// pointer, wrapping modulo NUM_CH. One-hot grant, zero when disabled.
module rr_arbiter
    import bram_mport_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [idx_w(NUM_CH)-1:0]  pointer,
    input  logic                      enable,
    output logic [NUM_CH-1:0]         grant
);

    localparam int IDX_W = idx_w(NUM_CH);

    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // Scan from pointer+1 upward (wrapping) and take the first requester.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx_s = IDX_W'((int'(pointer) + off) % NUM_CH);
            if (enable && !found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/bram_mport_if.sv
// Multi-requester front end for a single BRAM port. Requests are granted
// round-robin, run one at a time through ISSUE / RWAIT / VERIFY / RESP and
// complete with a one-cycle rsp_valid pulse to the owning channel. The
// pulse is registered, so it is seen in the first IDLE cycle after the
// access, where the next grant can already be made.
module bram_mport_if
    import bram_mport_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int WR_VERIFY = 0
) (
    input  logic                       axi_clk,
    input  logic                       axi_rst,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH-1:0]          req_we,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] req_wstrb,
    output logic [NUM_CH-1:0]          rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       busy,
    output logic                       clk_BRAM,
    output logic                       rst_BRAM,
    output logic [ADDR_W-1:0]          addr_BRAM,
    output logic [DATA_W-1:0]          dout_BRAM,
    input  logic [DATA_W-1:0]          din_BRAM,
    output logic                       en_BRAM,
    output logic [DATA_W/8-1:0]        we_BRAM
);

    localparam int   IDX_W     = idx_w(NUM_CH);
    localparam int   CNT_W     = lat_cnt_w(RD_LAT);
    localparam int   STRB_W    = DATA_W / 8;
    localparam int   LAST_CNT  = (RD_LAT > 1) ? (RD_LAT - 2) : 0;
    localparam logic VERIFY_ON = (WR_VERIFY == 1);

    // Parameter legality, rejected at elaboration.
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("bram_mport_if: NUM_CH must be in 1..8");
    end
    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $error("bram_mport_if: DATA_W must be a positive multiple of 8");
    end
    if (ADDR_W < 1) begin : g_bad_addr_w
        $error("bram_mport_if: ADDR_W must be at least 1");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("bram_mport_if: RD_LAT must be in 1..4");
    end
    if (WR_VERIFY != 0 && WR_VERIFY != 1) begin : g_bad_wr_verify
        $error("bram_mport_if: WR_VERIFY must be 0 or 1");
    end

    state_e              state_r;
    state_e              next_s;
    logic [IDX_W-1:0]    ptr_r;
    logic [IDX_W-1:0]    ch_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [CNT_W-1:0]    cnt_r;

    logic [NUM_CH-1:0]   grant_s;
    logic                xfer_s;
    logic [IDX_W-1:0]    gnt_idx_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [STRB_W-1:0]   sel_wstrb_s;
    logic [NUM_CH-1:0]   rsp_oh_s;
    logic                rsp_fire_s;

    logic                en_r;
    logic [STRB_W-1:0]   we_bram_r;
    logic [ADDR_W-1:0]   addr_bram_r;
    logic [DATA_W-1:0]   dout_bram_r;
    logic [NUM_CH-1:0]   rsp_valid_r;
    logic [DATA_W-1:0]   rsp_rdata_r;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req     (req_valid),
        .pointer (ptr_r),
        .enable  (state_r == ST_IDLE),
        .grant   (grant_s)
    );

    assign req_ready = grant_s;
    assign xfer_s    = (state_r == ST_IDLE) && (grant_s != '0);
    assign busy      = (state_r != ST_IDLE);
    assign clk_BRAM  = axi_clk;
    assign rst_BRAM  = ~axi_rst;
    assign en_BRAM   = en_r;
    assign we_BRAM   = we_bram_r;
    assign addr_BRAM = addr_bram_r;
    assign dout_BRAM = dout_bram_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;

    // Pick out the granted channel's index and request fields.
    always_comb begin
        gnt_idx_s   = '0;
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        sel_wstrb_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_s[i]) begin
                gnt_idx_s   = IDX_W'(i);
                sel_we_s    = req_we[i];
                sel_addr_s  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata_s = req_wdata[i*DATA_W +: DATA_W];
                sel_wstrb_s = req_wstrb[i*STRB_W +: STRB_W];
            end else begin
                gnt_idx_s = gnt_idx_s;
            end
        end
    end

    // One-hot form of the owning channel for the completion pulse.
    always_comb begin
        rsp_oh_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_r == IDX_W'(i)) begin
                rsp_oh_s[i] = 1'b1;
            end else begin
                rsp_oh_s[i] = 1'b0;
            end
        end
    end

    // A response is launched from RESP, or straight from ISSUE for an
    // unverified write.
    assign rsp_fire_s = (state_r == ST_RESP) ||
                        ((state_r == ST_ISSUE) && we_r && !VERIFY_ON);

    // State register.
    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    next_s = ST_ISSUE;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (we_r) begin
                    if (VERIFY_ON) begin
                        next_s = ST_VERIFY;
                    end else begin
                        next_s = ST_IDLE;
                    end
                end else if (RD_LAT == 1) begin
                    next_s = ST_RESP;
                end else begin
                    next_s = ST_RWAIT;
                end
            end
            ST_VERIFY: begin
                if (RD_LAT == 1) begin
                    next_s = ST_RESP;
                end else begin
                    next_s = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (cnt_r == CNT_W'(LAST_CNT)) begin
                    next_s = ST_RESP;
                end else begin
                    next_s = ST_RWAIT;
                end
            end
            ST_RESP: begin
                next_s = ST_IDLE;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // Request capture, round-robin pointer and read-latency counter.
    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            ptr_r  <= IDX_W'(NUM_CH - 1);
            ch_r   <= '0;
            we_r   <= 1'b0;
            addr_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (xfer_s) begin
                ptr_r  <= gnt_idx_s;
                ch_r   <= gnt_idx_s;
                we_r   <= sel_we_s;
                addr_r <= sel_addr_s;
            end else begin
                ptr_r  <= ptr_r;
                ch_r   <= ch_r;
                we_r   <= we_r;
                addr_r <= addr_r;
            end
            if (state_r == ST_RWAIT && next_s == ST_RWAIT) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // BRAM port registers: loaded for the ISSUE cycle at grant time and for
    // the VERIFY cycle out of ISSUE; zero in every other cycle.
    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            en_r        <= 1'b0;
            we_bram_r   <= '0;
            addr_bram_r <= '0;
            dout_bram_r <= '0;
        end else if (xfer_s) begin
            en_r        <= 1'b1;
            addr_bram_r <= sel_addr_s;
            we_bram_r   <= sel_we_s ? sel_wstrb_s : '0;
            dout_bram_r <= sel_we_s ? sel_wdata_s : '0;
        end else if ((state_r == ST_ISSUE) && we_r && VERIFY_ON) begin
            en_r        <= 1'b1;
            addr_bram_r <= addr_r;
            we_bram_r   <= '0;
            dout_bram_r <= '0;
        end else begin
            en_r        <= 1'b0;
            we_bram_r   <= '0;
            addr_bram_r <= '0;
            dout_bram_r <= '0;
        end
    end

    // Completion pulse and response data; read data is sampled from the
    // BRAM at the end of the RESP cycle.
    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
        end else if (rsp_fire_s) begin
            rsp_valid_r <= rsp_oh_s;
            rsp_rdata_r <= (state_r == ST_RESP) ? din_BRAM : '0;
        end else begin
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
        end
    end

endmodule
